// File: rtl/bin_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_mult_seq
// Description : Iterative shift-add multiplier with valid/ready handshakes.
//               Retires BITS_PER_CYCLE multiplier bits per RUN cycle, works
//               on operand magnitudes and re-applies the sign at the end.
//               Supports signed/unsigned operation per request and flags
//               products that do not fit in WIDTH bits.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_mult_seq #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 signed_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 ovf_o,
    output logic                 busy_o
);

    localparam int c_steps = WIDTH / BITS_PER_CYCLE;
    localparam int c_aw    = 2 * WIDTH + 1;
    localparam int c_cw    = $clog2(c_steps + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(c_steps - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state_q,   w_state_d;
    logic [c_aw-1:0]      r_mcand_q,   w_mcand_d;
    logic [WIDTH-1:0]     r_mplier_q,  w_mplier_d;
    logic [c_aw-1:0]      r_acc_q,     w_acc_d;
    logic [c_cw-1:0]      r_cnt_q,     w_cnt_d;
    logic                 r_neg_q,     w_neg_d;
    logic                 r_sgn_q,     w_sgn_d;
    logic [2*WIDTH-1:0]   r_product_q, w_product_d;
    logic                 r_ovf_q,     w_ovf_d;

    logic [c_aw-1:0]      w_partial;
    logic [c_aw-1:0]      w_acc_sum;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_mag;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH:0]       w_prod_top;
    logic                 w_prod_ovf;

    // The multiplicand register is pre-shifted each step, so the selected
    // multiple is already aligned to the accumulator.
    generate
        if (BITS_PER_CYCLE == 2) begin : g_radix4
            // Select 0, 1x, 2x or 3x multiplicand from the two multiplier LSBs
            always_comb begin
                w_partial = '0;
                case (r_mplier_q[1:0])
                    2'd1:    w_partial = r_mcand_q;
                    2'd2:    w_partial = r_mcand_q << 1;
                    2'd3:    w_partial = r_mcand_q + (r_mcand_q << 1);
                    default: w_partial = '0;
                endcase
            end
        end else begin : g_radix2
            assign w_partial = r_mplier_q[0] ? r_mcand_q : '0;
        end
    endgenerate

    // Most negative input has magnitude 2^(WIDTH-1), which still fits unsigned
    assign w_a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign w_b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    assign w_acc_sum  = r_acc_q + w_partial;
    assign w_mag      = w_acc_sum[2*WIDTH-1:0];
    assign w_prod     = r_neg_q ? -w_mag : w_mag;
    assign w_prod_top = w_prod[2*WIDTH-1:WIDTH-1];
    // Signed fits when the upper half plus the WIDTH-bit sign are a pure sign extension
    assign w_prod_ovf = r_sgn_q ? !((&w_prod_top) || !(|w_prod_top))
                                : (|w_prod[2*WIDTH-1:WIDTH]);

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence
    always_comb begin
        w_state_d   = r_state_q;
        w_mcand_d   = r_mcand_q;
        w_mplier_d  = r_mplier_q;
        w_acc_d     = r_acc_q;
        w_cnt_d     = r_cnt_q;
        w_neg_d     = r_neg_q;
        w_sgn_d     = r_sgn_q;
        w_product_d = r_product_q;
        w_ovf_d     = r_ovf_q;
        case (r_state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_mcand_d  = {{(WIDTH+1){1'b0}}, w_a_mag};
                    w_mplier_d = w_b_mag;
                    w_acc_d    = '0;
                    w_cnt_d    = '0;
                    w_neg_d    = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    w_sgn_d    = signed_i;
                    w_state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                w_acc_d    = w_acc_sum;
                w_mcand_d  = r_mcand_q << BITS_PER_CYCLE;
                w_mplier_d = r_mplier_q >> BITS_PER_CYCLE;
                w_cnt_d    = r_cnt_q + c_one;
                // Fixed step count: no early exit, latency is data-independent
                if (r_cnt_q == c_last) begin
                    w_product_d = w_prod;
                    w_ovf_d     = w_prod_ovf;
                    w_state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state_q   <= ST_IDLE;
            r_mcand_q   <= '0;
            r_mplier_q  <= '0;
            r_acc_q     <= '0;
            r_cnt_q     <= '0;
            r_neg_q     <= 1'b0;
            r_sgn_q     <= 1'b0;
            r_product_q <= '0;
            r_ovf_q     <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_mcand_q   <= w_mcand_d;
            r_mplier_q  <= w_mplier_d;
            r_acc_q     <= w_acc_d;
            r_cnt_q     <= w_cnt_d;
            r_neg_q     <= w_neg_d;
            r_sgn_q     <= w_sgn_d;
            r_product_q <= w_product_d;
            r_ovf_q     <= w_ovf_d;
        end
    end

    // Handshake outputs are pure decodes of the state register
    assign in_ready  = (r_state_q == ST_IDLE);
    assign out_valid = (r_state_q == ST_DONE);
    assign busy_o    = (r_state_q != ST_IDLE);
    assign product_o = r_product_q;
    assign ovf_o     = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_mult_seq
// Description : Scoreboard bench for bin_mult_seq, one 8-bit radix-2 and one
//               16-bit radix-4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_mult_seq;

    localparam int PERIOD = 10;
    localparam int HALF   = 5;

    typedef struct {
        logic [31:0] prod;
        logic        ovf;
        time         t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv8 = 1'b0, s8 = 1'b0, ord8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ir8, ov8, ovf8, busy8;
    logic [15:0] prod8;

    logic        iv16 = 1'b0, s16 = 1'b0, ord16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ir16, ov16, ovf16, busy16;
    logic [31:0] prod16;

    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q16[$];
    exp_t m8, m16, es;
    logic ov8_prev  = 1'b0;
    logic ov16_prev = 1'b0;

    bin_mult_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
        .wb_clk_i (clk),   .wb_rst_i (rst),
        .in_valid (iv8),   .in_ready (ir8),
        .a_i      (a8),    .b_i      (b8),    .signed_i (s8),
        .out_valid(ov8),   .out_ready(ord8),
        .product_o(prod8), .ovf_o    (ovf8),  .busy_o   (busy8)
    );

    bin_mult_seq #(.WIDTH(16), .BITS_PER_CYCLE(2)) u_dut16 (
        .wb_clk_i (clk),    .wb_rst_i (rst),
        .in_valid (iv16),   .in_ready (ir16),
        .a_i      (a16),    .b_i      (b16),   .signed_i (s16),
        .out_valid(ov16),   .out_ready(ord16),
        .product_o(prod16), .ovf_o    (ovf16), .busy_o   (busy16)
    );

    always #(HALF) clk = ~clk;

    initial begin
        #(PERIOD * 60000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor for the 8-bit instance: latency on rise, result on consume
    always @(negedge clk) begin
        if (!rst) begin
            if (ov8 && !ov8_prev) begin
                if (q8.size() == 0) chk("m8_unexpected_valid", 1, 0);
                else chk("m8_latency", ($time - HALF - q8[0].t) / PERIOD, 8);
            end
            if (ov8 && ord8) begin
                if (q8.size() == 0) chk("m8_unexpected_result", 1, 0);
                else begin
                    m8 = q8.pop_front();
                    chk("m8_product", prod8, m8.prod[15:0]);
                    chk("m8_ovf", ovf8, m8.ovf);
                end
            end
        end
        ov8_prev = ov8;
    end

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        if (!rst) begin
            if (ov16 && !ov16_prev) begin
                if (q16.size() == 0) chk("m16_unexpected_valid", 1, 0);
                else chk("m16_latency", ($time - HALF - q16[0].t) / PERIOD, 8);
            end
            if (ov16 && ord16) begin
                if (q16.size() == 0) chk("m16_unexpected_result", 1, 0);
                else begin
                    m16 = q16.pop_front();
                    chk("m16_product", prod16, m16.prod);
                    chk("m16_ovf", ovf16, m16.ovf);
                end
            end
        end
        ov16_prev = ov16;
    end

    task automatic drain8();
        for (int i = 0; i < 100 && q8.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain8", q8.size(), 0);
        q8.delete();
    endtask

    task automatic drain16();
        for (int i = 0; i < 100 && q16.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain16", q16.size(), 0);
        q16.delete();
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] ep, input logic eo);
        exp_t e;
        for (int k = 0; k < 100 && !ir8; k++) begin
            @(posedge clk); #1;
        end
        a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
        @(posedge clk); e.t = $time; #1;
        iv8 = 1'b0;
        e.prod = {16'h0000, ep}; e.ovf = eo;
        q8.push_back(e);
        drain8();
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [31:0] ep, input logic eo);
        exp_t e;
        for (int k = 0; k < 100 && !ir16; k++) begin
            @(posedge clk); #1;
        end
        a16 = a; b16 = b; s16 = s; iv16 = 1'b1;
        @(posedge clk); e.t = $time; #1;
        iv16 = 1'b0;
        e.prod = ep; e.ovf = eo;
        q16.push_back(e);
        drain16();
    endtask

    // Reference: plain integer multiply and range test
    function automatic logic [32:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint pa, pb, p;
        logic   ov;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            p  = pa * pb;
            ov = (p > 32767) || (p < -32768);
        end else begin
            pa = longint'(a);
            pb = longint'(b);
            p  = pa * pb;
            ov = (p > 65535);
        end
        return {ov, p[31:0]};
    endfunction

    initial begin
        logic [32:0] r;
        logic [15:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready8", ir8, 1);
        chk("rst_out_valid8", ov8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_product8", prod8, 0);
        chk("rst_ovf8", ovf8, 0);
        chk("rst_in_ready16", ir16, 1);
        chk("rst_product16", prod16, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1..T3 plus boundary directed vectors
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        op8(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        op8(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0);
        op8(8'h00, 8'hFF, 1'b1, 16'h0000, 1'b0);
        op8(8'h0F, 8'h11, 1'b0, 16'h00FF, 1'b0);
        op8(8'h7F, 8'h81, 1'b1, 16'hC0FF, 1'b1);
        op8(8'h80, 8'h01, 1'b1, 16'hFF80, 1'b0);
        op8(8'h80, 8'hFF, 1'b1, 16'h0080, 1'b1);
        op8(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0);
        op8(8'h10, 8'h0F, 1'b0, 16'h00F0, 1'b0);

        // T4 backpressure with in_valid held high throughout
        ord8 = 1'b0;
        a8 = 8'd3; b8 = 8'd4; s8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); es.t = $time; #1;
        es.prod = 32'h0000_000C; es.ovf = 1'b0;
        q8.push_back(es);
        a8 = 8'd9; b8 = 8'd9;
        for (int k = 0; k < 50 && !ov8; k++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_product", prod8, 16'h000C);
            chk("t4_in_ready_low", ir8, 0);
            @(posedge clk); #1;
        end
        chk("t4_still_valid", ov8, 1);
        ord8 = 1'b1;
        @(posedge clk); #1;
        chk("t4_idle_in_ready", ir8, 1);
        chk("t4_out_valid_low", ov8, 0);
        chk("t4_no_accept_on_consume", busy8, 0);
        @(posedge clk); es.t = $time; #1;
        iv8 = 1'b0;
        es.prod = 32'h0000_0051; es.ovf = 1'b0;
        q8.push_back(es);
        chk("t4_next_accepted", busy8, 1);
        drain8();

        // T5 asynchronous reset after three RUN edges
        chk("t5_idle_before", ir8, 1);
        a8 = 8'd200; b8 = 8'd200; s8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_in_ready", ir8, 1);
        chk("t5_out_valid", ov8, 0);
        chk("t5_busy", busy8, 0);
        chk("t5_product", prod8, 0);
        chk("t5_ovf", ovf8, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        q8.delete();
        @(posedge clk); #1;
        op8(8'd7, 8'd6, 1'b0, 16'h002A, 1'b0);

        // T6 wide radix-4 instance
        op16(16'hFFFF, 16'h0001, 1'b0, 32'h0000_FFFF, 1'b0);
        op16(16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000, 1'b1);
        op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b1);
        op16(16'h8000, 16'hFFFF, 1'b1, 32'h0000_8000, 1'b1);
        for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < 1000; n++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                if (n % 4 == 0) rb = 16'($urandom_range(0, 255));
                r = ref16(ra, rb, m[0]);
                op16(ra, rb, m[0], r[31:0], r[32]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
